// File: rtl/axi_lite_resp_regbank_if.sv
// AXI4-Lite bus bundle between a single initiator and the register-bank responder.
interface axi_lite_resp_regbank_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi_lite_resp_regbank.sv
// AXI4-Lite responder holding NUM_REGS 32-bit registers; AW and W are buffered
// one-deep and independently, out-of-range accesses answer SLVERR.
module axi_lite_resp_regbank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESET,
    axi_lite_resp_regbank_if.slave s_axi,
    output logic [15:0]            WR_COUNT,
    output logic [15:0]            RD_COUNT
);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NB    = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [C_S_AXI_DATA_WIDTH-1:0] data;
        logic [NB-1:0]                 strb;
    } wbuf_t;

    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0][NB-1:0]                 byte_we;

    logic                          aw_full, w_full;
    logic [IDX_W-1:0]              aw_idx;
    wbuf_t                         w_buf;
    logic                          bvalid;
    logic [1:0]                    bresp;
    logic                          rvalid;
    logic [1:0]                    rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

    logic                          aw_hs, w_hs, ar_hs, commit;
    logic                          aw_in_range, ar_in_range;
    logic [IDX_W-1:0]              ar_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_val;
    logic                          unused_bits;

    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    assign aw_hs  = s_axi.S_AXI_AWVALID && !aw_full;
    assign w_hs   = s_axi.S_AXI_WVALID && !w_full;
    assign ar_hs  = s_axi.S_AXI_ARVALID && !rvalid;
    // A pending B only blocks the commit if the initiator is not taking it this cycle.
    assign commit = aw_full && w_full && (!bvalid || s_axi.S_AXI_BREADY);

    assign ar_idx      = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign aw_in_range = int'(aw_idx) < NUM_REGS;
    assign ar_in_range = int'(ar_idx) < NUM_REGS;

    assign s_axi.S_AXI_AWREADY = !aw_full;
    assign s_axi.S_AXI_WREADY  = !w_full;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp;
    assign s_axi.S_AXI_ARREADY = !rvalid;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RRESP   = rresp;
    assign s_axi.S_AXI_RDATA   = rdata;

    // Out-of-range indices match no register and so read back as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (int'(ar_idx) == i) rd_val = regs[i];
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_we
        assign byte_we[r] = (commit && int'(aw_idx) == r) ? w_buf.strb : '0;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            regs <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                for (int b = 0; b < NB; b++)
                    if (byte_we[r][b]) regs[r][8*b +: 8] <= w_buf.data[8*b +: 8];
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_full <= 1'b0;
            aw_idx  <= '0;
            w_full  <= 1'b0;
            w_buf   <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            if (commit) aw_full <= 1'b0;
            else if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (commit) w_full <= 1'b0;
            else if (w_hs) begin
                w_full <= 1'b1;
                w_buf  <= '{data: s_axi.S_AXI_WDATA, strb: s_axi.S_AXI_WSTRB};
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi.S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read data is sampled from regs before any same-cycle commit lands.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rvalid <= 1'b0;
            rresp  <= RESP_OKAY;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata  <= rd_val;
        end else if (s_axi.S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            WR_COUNT <= '0;
            RD_COUNT <= '0;
        end else begin
            if (bvalid && s_axi.S_AXI_BREADY) WR_COUNT <= WR_COUNT + 16'd1;
            if (rvalid && s_axi.S_AXI_RREADY) RD_COUNT <= RD_COUNT + 16'd1;
        end
    end
endmodule
